branch_target_buffer: RTL

- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch side: combinational lookup by current PC. Drives the btb_pc_valid, btb_pc_predictTaken and btb_target_pc inputs of the next-PC select logic.
- Execute side: resolved branches train the table on the clock edge.
- Producer end of the BTB-prediction interface that the PC-update stage consumes.

---
 rtl/branch_target_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_STATS_EN to add lookup/hit/mispredict statistics counters.
module branch_target_buffer #(
  parameter  int ENTRIES = 64,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        btb_pc_valid,
  output logic        btb_pc_predictTaken,
  output logic [31:0] btb_target_pc,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken,
`ifdef BTB_STATS_EN
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_mispredicts,
`endif
  input  logic        flush
);

  logic               valid  [ENTRIES];
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [31:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_hit;
  logic [INDEX_W-1:0] wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic               wr_hit;
  logic               unused_bits;

  // Byte offset within the instruction word never participates in indexing.
  assign unused_bits = ^{pc[1:0], update_pc[1:0]};

  assign rd_idx = pc[INDEX_W+1:2];
  assign rd_tag = pc[31:INDEX_W+2];
  assign rd_hit = valid[rd_idx] && (tag[rd_idx] == rd_tag);

  assign wr_idx = update_pc[INDEX_W+1:2];
  assign wr_tag = update_pc[31:INDEX_W+2];
  assign wr_hit = valid[wr_idx] && (tag[wr_idx] == wr_tag);

  // Lookup reads the array directly, so a same-cycle update is not bypassed.
  assign btb_pc_valid        = rd_hit;
  assign btb_pc_predictTaken = rd_hit & ctr[rd_idx][1];
  assign btb_target_pc       = rd_hit ? target[rd_idx] : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= 32'h0;
        ctr[i]    <= 2'b01;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
      end
    end else if (update_en) begin
      if (wr_hit) begin
        if (update_taken) begin
          if (ctr[wr_idx] != 2'b11) ctr[wr_idx] <= ctr[wr_idx] + 2'b01;
          target[wr_idx] <= update_target;
        end else begin
          if (ctr[wr_idx] != 2'b00) ctr[wr_idx] <= ctr[wr_idx] - 2'b01;
        end
      end else if (update_taken) begin
        // Allocation overwrites whatever branch aliased into this slot.
        valid[wr_idx]  <= 1'b1;
        tag[wr_idx]    <= wr_tag;
        target[wr_idx] <= update_target;
        ctr[wr_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic wr_pred_taken;
  assign wr_pred_taken = wr_hit & ctr[wr_idx][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_lookups     <= 32'h0;
      stat_hits        <= 32'h0;
      stat_mispredicts <= 32'h0;
    end else begin
      stat_lookups <= stat_lookups + 32'd1;
      if (rd_hit) stat_hits <= stat_hits + 32'd1;
      if (update_en && (wr_pred_taken != update_taken))
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
